// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Index counter width; a single-chunk configuration still needs one bit.
  function automatic int unsigned calc_idx_w(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// with valid/ready handshakes on operands and result.
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_next;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CHUNK-1:0] slice_s;
  logic             slice_co, slice_cmsb;
  logic             load, step, last;

  // Operands shift right each cycle so the adder always sees the low slice.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_q[CHUNK-1:0]),
    .y     (b_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // New slice enters at the top; after NCHUNK shifts chunk 0 sits at the bottom.
  assign acc_next = WIDTH'({slice_s, acc_q} >> CHUNK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      if (load) begin
        a_q     <= a;
        b_q     <= b ^ {WIDTH{sub}};
        carry_q <= sub | cin;
        idx_q   <= '0;
      end else if (step) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        carry_q <= slice_co;
        acc_q   <= acc_next;
        idx_q   <= idx_q + IDX_W'(1);
        // Result registers change only when a full result is ready.
        if (last) begin
          sum  <= acc_next;
          cout <= slice_co;
          ovf  <= slice_cmsb ^ slice_co;
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench: a 16/4 and an 8/8 instance against an arithmetic reference model.
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, iv16, ir16, ov16, or16, co16, of16;
  logic [7:0]  a8, b8, sum8;
  logic        cin8, sub8, iv8, ir8, ov8, or8, co8, of8;

  int n_cmp = 0;
  int n_err = 0;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(co16), .ovf(of16)
  );

  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(co8), .ovf(of8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain W+1-bit arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] full;
    logic [15:0] m, bb, s;
    logic        c0, co, ov;
    m    = (w == 16) ? 16'hFFFF : 16'h00FF;
    bb   = (sub ? ~b : b) & m;
    c0   = sub ? 1'b1 : cin;
    full = {1'b0, a & m} + {1'b0, bb} + {16'b0, c0};
    s    = full[15:0] & m;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic drive_in(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic v);
    if (d == 0) begin
      a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = v;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; iv8 = v;
    end
  endtask

  task automatic set_ready(input int d, input logic r);
    if (d == 0) or16 = r;
    else        or8  = r;
  endtask

  function automatic logic [15:0] get_sum(input int d);
    return (d == 0) ? sum16 : {8'h00, sum8};
  endfunction
  function automatic logic get_ir(input int d); return (d == 0) ? ir16 : ir8; endfunction
  function automatic logic get_ov(input int d); return (d == 0) ? ov16 : ov8; endfunction
  function automatic logic get_co(input int d); return (d == 0) ? co16 : co8; endfunction
  function automatic logic get_of(input int d); return (d == 0) ? of16 : of8; endfunction

  // One full transaction: handshake, latency, result, optional stall with noise, drain.
  task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input int stall, input string tag);
    int          w, nch, t, lat;
    logic [17:0] exp;
    w   = (d == 0) ? 16 : 8;
    nch = (d == 0) ? 4 : 1;
    exp = model(w, a, b, cin, sub);
    t = 0;
    while (!get_ir(d) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, " in_ready"}, 64'(get_ir(d)), 64'(1));
    drive_in(d, a, b, cin, sub, 1'b1);
    set_ready(d, 1'b0);
    @(negedge clk);
    drive_in(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    lat = 0;
    while (!get_ov(d) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(nch));
    check({tag, " sum"}, 64'(get_sum(d)), 64'(exp[15:0]));
    check({tag, " cout"}, 64'(get_co(d)), 64'(exp[16]));
    check({tag, " ovf"}, 64'(get_of(d)), 64'(exp[17]));
    check({tag, " busy"}, 64'(get_ir(d)), 64'(0));
    for (int i = 0; i < stall; i++) begin
      drive_in(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check({tag, " hold valid"}, 64'(get_ov(d)), 64'(1));
      check({tag, " hold sum"}, 64'(get_sum(d)), 64'(exp[15:0]));
      check({tag, " hold flags"}, 64'({get_of(d), get_co(d)}), 64'(exp[17:16]));
      check({tag, " hold in_ready"}, 64'(get_ir(d)), 64'(0));
    end
    drive_in(d, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    set_ready(d, 1'b1);
    @(negedge clk);
    set_ready(d, 1'b0);
    check({tag, " drained"}, 64'(get_ov(d)), 64'(0));
    check({tag, " ready again"}, 64'(get_ir(d)), 64'(1));
    check({tag, " sum kept"}, 64'(get_sum(d)), 64'(exp[15:0]));
    if (stall >= 5) begin
      repeat (3) @(negedge clk);
      check({tag, " single result"}, 64'(get_ov(d)), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    drive_in(1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    or16 = 1'b0;
    or8  = 1'b0;
    #12;
    check("rst in_ready16", 64'(ir16), 64'(1));
    check("rst out_valid16", 64'(ov16), 64'(0));
    check("rst out16", 64'({of16, co16, sum16}), 64'(0));
    check("rst in_ready8", 64'(ir8), 64'(1));
    check("rst out8", 64'({ov8, of8, co8, sum8}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "add00ff");
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, "addwrap");
    do_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "addovf");
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 2, "subneg");
    do_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, "subovf");
    do_op(0, 16'h1357, 16'h0246, 1'b1, 1'b0, 5, "backpressure");

    // Abort during the second CALC cycle.
    drive_in(0, 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive_in(0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(ov16), 64'(0));
    check("abort sum", 64'(sum16), 64'(0));
    check("abort flags", 64'({of16, co16}), 64'(0));
    check("abort in_ready", 64'(ir16), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort no result", 64'(ov16), 64'(0));
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 0, "after abort");

    do_op(1, 16'h00F0, 16'h0010, 1'b1, 1'b0, 0, "w8 add");
    do_op(1, 16'h0080, 16'h0001, 1'b0, 1'b1, 2, "w8 sub");

    for (int i = 0; i < 40; i++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "rand16");
    for (int i = 0; i < 20; i++)
      do_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), "rand8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
- Parametrised multi-cycle adder/subtractor. It generalises the fixed 4-bit ripple-carry adder to WIDTH bits.
- Each cycle it processes one CHUNK-bit slice, LSB slice first, and registers the carry between slices. This keeps the combinational carry path at CHUNK bits regardless of WIDTH.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Adds a subtract mode and a signed-overflow flag.
- Sits between operand-producing logic and any downstream result consumer in the datapath test designs.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A−B (computed as A+~B+1; cin ignored).
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; in sub mode 1 means no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Local constant NCHUNK = WIDTH/CHUNK.
- Registers: a_q, b_q (b already inverted when sub=1), carry_q, sum_q, idx (counter 0..NCHUNK−1), cout_q, ovf_q, and FSM state.
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; idx=0; carry_q=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b^{WIDTH{sub}}, and carry_q = sub ? 1 : cin; idx=0; go to CALC.
- FSM CALC:
  - in_ready=0, out_valid=0.
  - Each cycle, chunk idx computes a_q[idx] + b_q[idx] + carry_q. The slice is written into sum_q[idx*CHUNK +: CHUNK] and carry_q takes the slice carry-out.
  - On the last chunk (idx=NCHUNK−1), record cout_q = slice carry-out and ovf_q = carry into bit WIDTH−1 XOR slice carry-out, then go to DONE. Otherwise idx++.
- FSM DONE:
  - out_valid=1; sum/cout/ovf driven from registers and held stable while out_ready=0.
  - On out_ready: go to IDLE with out_valid=0 next cycle.
- Latency: input handshake at edge k ⇒ out_valid=1 after edge k+NCHUNK. Throughput is one result per NCHUNK+2 cycles at best.
- in_valid while not in IDLE is ignored; operands are not sampled.
- Changes to a/b/cin/sub after the handshake have no effect on the operation in flight.
- sum/cout/ovf retain the last result after the output handshake until the next DONE. Only out_valid qualifies them.
- CHUNK=WIDTH (NCHUNK=1): exactly one CALC cycle; the same rules apply.
- Reset asserted mid-CALC or in DONE: the operation is aborted, all outputs return to reset values immediately, and no partial result is presented.
- in_valid and out_ready both high in DONE: only the output handshake completes. in_ready is 0 in DONE, so no new operands are taken that cycle.

Decomposition:
- Shared package/include holds:
  - state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2;
  - helper function/constant computing NCHUNK and idx width (clog2(NCHUNK), min 1).
- One sub-module: chunk_adder. It is a purely combinational CHUNK-bit ripple adder with inputs (x, y, ci) and outputs (s, co, c_msb), where c_msb is the carry into the slice MSB and feeds ovf. It is instantiated once and time-multiplexed across chunks.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
- a=0x00FF, b=0x0001, cin=0, sub=0 → out_valid 4 cycles after handshake; sum=0x0100, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid and operands → sum/cout/ovf stable, in_ready=0; only one result is produced.
- rst_n pulsed low during the 2nd CALC cycle → out_valid=0, sum=0, in_ready=1 immediately. A subsequent op a=0x1234, b=0x1111 → sum=0x2345.
- WIDTH=8, CHUNK=8: a=0xF0, b=0x10, cin=1 → sum=0x01, cout=1, out_valid 1 cycle after handshake. Also run a random back-to-back stream vs. a reference model.
